// File: rtl/noc_echo_pkg.sv
// Shared definitions for the NoC echo endpoint and bench models: FSM states,
// header field layout within the top 13 bits of flit 0, and the src/dest swap.
package noc_echo_pkg;

    typedef enum logic [1:0] {
        RECV  = 2'd0,
        DRAIN = 2'd1,
        SEND  = 2'd2
    } state_t;

    // Bit positions are relative to the 13-bit header slice flit[FW-1:FW-13].
    localparam int HDR_W    = 13;
    localparam int DEST_MSB = 12;
    localparam int DEST_W   = 5;
    localparam int CLASS_W  = 3;
    localparam int SRC_MSB  = 4;
    localparam int SRC_W    = 5;

    function automatic logic [HDR_W-1:0] swap_hdr(input logic [HDR_W-1:0] hdr);
        logic [HDR_W-1:0] res;
        res = hdr;
        res[DEST_MSB -: DEST_W] = hdr[SRC_MSB -: SRC_W];
        res[SRC_MSB -: SRC_W]   = hdr[DEST_MSB -: DEST_W];
        return res;
    endfunction

endpackage

// File: rtl/noc_echo_buffer.sv
// Packet storage for the echo endpoint: register array with one write port
// and one asynchronous read port.
module noc_echo_buffer #(
    parameter int FLIT_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int AW         = 3
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [FLIT_WIDTH-1:0] wr_data,
    input  logic [AW-1:0]         rd_addr,
    output logic [FLIT_WIDTH-1:0] rd_data
);

    logic [FLIT_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/noc_echo_endpoint.sv
// NoC loopback endpoint: buffers a packet from the tile, swaps src/dest in
// the header and returns it; misaddressed or oversized packets are dropped.
module noc_echo_endpoint
    import noc_echo_pkg::*;
#(
    parameter int FLIT_WIDTH  = 32,
    parameter int MAX_PKT_LEN = 8,
    parameter int TILE_ID     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FLIT_WIDTH-1:0] in_flit,
    input  logic                  in_last,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [FLIT_WIDTH-1:0] out_flit,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [15:0]           pkt_count,
    output logic [15:0]           drop_count
);

    localparam int AW = (MAX_PKT_LEN > 1) ? $clog2(MAX_PKT_LEN) : 1;
    localparam int PW = $clog2(MAX_PKT_LEN) + 1;
    localparam logic [PW-1:0]     LAST_SLOT = PW'(MAX_PKT_LEN - 1);
    localparam logic [PW-1:0]     PTR_ONE   = PW'(1);
    localparam logic [DEST_W-1:0] TILE_ADDR = DEST_W'(TILE_ID);

    state_t              state_q, state_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]       len_q, len_d;
    logic [DEST_W-1:0]   hdr_dest_q, hdr_dest_d;
    logic [15:0]         pkt_count_q, pkt_count_d;
    logic [15:0]         drop_count_q, drop_count_d;

    logic                  in_fire;
    logic                  out_fire;
    logic                  wr_en;
    logic [DEST_W-1:0]     pkt_dest;
    logic [FLIT_WIDTH-1:0] rd_data;

    assign in_ready   = (state_q != SEND);
    assign out_valid  = (state_q == SEND);
    assign in_fire    = in_valid && in_ready;
    assign out_fire   = out_valid && out_ready;
    assign wr_en      = in_fire && (state_q == RECV);
    assign pkt_count  = pkt_count_q;
    assign drop_count = drop_count_q;

    // A single-flit packet carries its header on the last flit, so it is
    // taken straight from the input rather than from the captured copy.
    assign pkt_dest = (wr_ptr_q == '0) ? in_flit[FLIT_WIDTH-1 -: DEST_W] : hdr_dest_q;

    noc_echo_buffer #(
        .FLIT_WIDTH (FLIT_WIDTH),
        .DEPTH      (MAX_PKT_LEN),
        .AW         (AW)
    ) u_buffer (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q[AW-1:0]),
        .wr_data (in_flit),
        .rd_addr (rd_ptr_q[AW-1:0]),
        .rd_data (rd_data)
    );

    always_comb begin
        out_flit = '0;
        out_last = 1'b0;
        if (state_q == SEND) begin
            out_flit = rd_data;
            if (rd_ptr_q == '0) begin
                out_flit[FLIT_WIDTH-1 -: HDR_W] = swap_hdr(rd_data[FLIT_WIDTH-1 -: HDR_W]);
            end
            out_last = (rd_ptr_q == (len_q - PTR_ONE));
        end
    end

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        len_d        = len_q;
        hdr_dest_d   = hdr_dest_q;
        pkt_count_d  = pkt_count_q;
        drop_count_d = drop_count_q;
        case (state_q)
            RECV: begin
                if (in_fire) begin
                    if (wr_ptr_q == '0) begin
                        hdr_dest_d = in_flit[FLIT_WIDTH-1 -: DEST_W];
                    end
                    if (in_last) begin
                        if (pkt_dest == TILE_ADDR) begin
                            state_d  = SEND;
                            len_d    = wr_ptr_q + PTR_ONE;
                            wr_ptr_d = wr_ptr_q + PTR_ONE;
                        end else begin
                            drop_count_d = drop_count_q + 16'd1;
                            wr_ptr_d     = '0;
                        end
                    end else if (wr_ptr_q == LAST_SLOT) begin
                        state_d = DRAIN;
                    end else begin
                        wr_ptr_d = wr_ptr_q + PTR_ONE;
                    end
                end
            end
            DRAIN: begin
                if (in_fire && in_last) begin
                    drop_count_d = drop_count_q + 16'd1;
                    wr_ptr_d     = '0;
                    state_d      = RECV;
                end
            end
            SEND: begin
                if (out_fire) begin
                    if (out_last) begin
                        pkt_count_d = pkt_count_q + 16'd1;
                        rd_ptr_d    = '0;
                        wr_ptr_d    = '0;
                        state_d     = RECV;
                    end else begin
                        rd_ptr_d = rd_ptr_q + PTR_ONE;
                    end
                end
            end
            default: begin
                state_d = RECV;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RECV;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            len_q        <= '0;
            hdr_dest_q   <= '0;
            pkt_count_q  <= '0;
            drop_count_q <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            len_q        <= len_d;
            hdr_dest_q   <= hdr_dest_d;
            pkt_count_q  <= pkt_count_d;
            drop_count_q <= drop_count_d;
        end
    end

endmodule

// File: tb/tb_noc_echo_endpoint.sv
// Self-checking bench for noc_echo_endpoint: directed scenarios plus random
// packets compared against a queue-based model of the echo behaviour.
module tb_noc_echo_endpoint;

    localparam int FW      = 32;
    localparam int MAX_LEN = 8;
    localparam int TILE    = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [FW-1:0] in_flit;
    logic          in_last;
    logic          in_valid;
    logic          in_ready;
    logic [FW-1:0] out_flit;
    logic          out_last;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   pkt_count;
    logic [15:0]   drop_count;

    logic [31:0] tx_pkt[$];
    logic [31:0] exp_q[$];
    logic [15:0] exp_pkt;
    logic [15:0] exp_drop;
    int          check_count;
    int          pass_count;

    noc_echo_endpoint #(
        .FLIT_WIDTH  (FW),
        .MAX_PKT_LEN (MAX_LEN),
        .TILE_ID     (TILE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_flit    (in_flit),
        .in_last    (in_last),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_flit   (out_flit),
        .out_last   (out_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .pkt_count  (pkt_count),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Drives tx_pkt flit by flit; called and returns on a falling edge.
    task automatic applyStimulus();
        int wait_cycles;
        for (int i = 0; i < tx_pkt.size(); i++) begin
            in_valid = 1'b1;
            in_flit  = tx_pkt[i];
            in_last  = (i == tx_pkt.size() - 1);
            wait_cycles = 0;
            while (!in_ready && wait_cycles < 100) begin
                @(negedge clk);
                wait_cycles++;
            end
            if (!in_ready) begin
                checkOutput("in_ready_timeout", {31'd0, in_ready}, 32'd1);
                break;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_flit  = '0;
    endtask

    task automatic collectEcho(input int stall_pct);
        int stalls;
        for (int i = 0; i < exp_q.size(); i++) begin
            stalls = 0;
            forever begin
                out_ready = ($urandom_range(0, 99) >= stall_pct) || (stalls >= 6);
                checkOutput("echo_valid", {31'd0, out_valid}, 32'd1);
                checkOutput("echo_flit", out_flit, exp_q[i]);
                checkOutput("echo_last", {31'd0, out_last}, {31'd0, (i == exp_q.size() - 1)});
                checkOutput("send_in_ready", {31'd0, in_ready}, 32'd0);
                @(negedge clk);
                if (out_ready) break;
                stalls++;
            end
        end
        out_ready = 1'b0;
        checkOutput("post_send_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("post_send_ready", {31'd0, in_ready}, 32'd1);
    endtask

    // Reference model: a packet echoes when addressed here and it fits the
    // buffer; the returned header has the 5-bit dest and src fields exchanged.
    task automatic runPacket(input int stall_pct);
        logic [31:0] hdr;
        logic [31:0] dest;
        logic [31:0] src;
        bit          echo;
        hdr  = tx_pkt[0];
        dest = (hdr >> 27) & 32'h1F;
        src  = (hdr >> 19) & 32'h1F;
        echo = (dest == TILE) && (tx_pkt.size() <= MAX_LEN);
        exp_q = {};
        if (echo) begin
            exp_q = tx_pkt;
            exp_q[0] = (hdr & 32'h0707_FFFF) | (src << 27) | (dest << 19);
        end
        out_ready = 1'b0;
        applyStimulus();
        if (echo) begin
            checkOutput("first_valid_latency", {31'd0, out_valid}, 32'd1);
            collectEcho(stall_pct);
            exp_pkt = exp_pkt + 16'd1;
        end else begin
            exp_drop = exp_drop + 16'd1;
            checkOutput("drop_no_output", {31'd0, out_valid}, 32'd0);
            checkOutput("drop_in_ready", {31'd0, in_ready}, 32'd1);
        end
        checkOutput("pkt_count", {16'd0, pkt_count}, {16'd0, exp_pkt});
        checkOutput("drop_count", {16'd0, drop_count}, {16'd0, exp_drop});
    endtask

    function automatic logic [31:0] makeHeader(input int dest, input int src);
        logic [31:0] low;
        low = $urandom & 32'h0007_FFFF;
        return (32'(dest) << 27) | (32'($urandom_range(0, 7)) << 24) | (32'(src) << 19) | low;
    endfunction

    initial begin
        int len;
        int dest;
        check_count = 0;
        pass_count  = 0;
        exp_pkt     = '0;
        exp_drop    = '0;
        rst       = 1'b1;
        in_flit   = '0;
        in_last   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_out_last", {31'd0, out_last}, 32'd0);
        checkOutput("reset_out_flit", out_flit, 32'd0);
        checkOutput("reset_pkt_count", {16'd0, pkt_count}, 32'd0);
        checkOutput("reset_drop_count", {16'd0, drop_count}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] 3-flit echo");
        tx_pkt = {32'h0818_0000, 32'hDEAD_BEEF, 32'h1234_5678};
        runPacket(0);

        $display("[TB] single flit");
        tx_pkt = {32'h0810_00AA};
        runPacket(0);

        $display("[TB] misaddressed");
        tx_pkt = {32'h1018_0000, 32'h5555_AAAA};
        runPacket(0);

        $display("[TB] oversize then valid 2-flit");
        tx_pkt = {};
        tx_pkt.push_back(makeHeader(TILE, 4));
        for (int i = 1; i < 10; i++) tx_pkt.push_back($urandom);
        runPacket(0);
        tx_pkt = {makeHeader(TILE, 7), 32'hCAFE_F00D};
        runPacket(0);

        $display("[TB] backpressure");
        tx_pkt = {makeHeader(TILE, 9), $urandom, $urandom, $urandom};
        runPacket(60);

        $display("[TB] reset mid-op");
        tx_pkt = {32'h0818_0000, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
        out_ready = 1'b0;
        applyStimulus();
        out_ready = 1'b1;
        checkOutput("midop_flit0", out_flit, 32'h1808_0000);
        @(negedge clk);
        checkOutput("midop_flit1", out_flit, 32'h1111_1111);
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_pkt  = '0;
        exp_drop = '0;
        checkOutput("midop_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("midop_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("midop_pkt_count", {16'd0, pkt_count}, 32'd0);
        checkOutput("midop_drop_count", {16'd0, drop_count}, 32'd0);
        tx_pkt = {makeHeader(TILE, 2), 32'hABCD_0123, 32'h4567_89AB};
        runPacket(30);

        $display("[TB] random packets");
        for (int n = 0; n < 30; n++) begin
            len  = $urandom_range(1, 10);
            dest = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : TILE;
            tx_pkt = {};
            tx_pkt.push_back(makeHeader(dest, $urandom_range(0, 31)));
            for (int i = 1; i < len; i++) tx_pkt.push_back($urandom);
            runPacket(40);
        end

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
